decode_execute_reg: RTL

//  ID/EX pipeline register, directly downstream of decode's control_unit.

---
 rtl/decode_execute_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decode_execute_reg.sv
// rtl/decode_execute_reg.sv - ID/EX pipeline register with load-use hazard detection
//
// Purpose: registers the decode-stage control word, operands and register
// indices for the execute stage, resolves the destination register index,
// and flags load-use hazards against the instruction currently in decode.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stall, flush          hold / bubble controls (flush wins)
//   id_*                  decode-stage control, operands, register fields
//   ex_*                  registered copies of id_* for execute
//   ex_write_reg          resolved destination index
//   ex_valid              1 = real instruction, 0 = bubble
//   load_use_hazard       combinational; IF/ID must hold while set
module decode_execute_reg #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic [2:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dest,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic              id_jump_reg,
    input  logic              id_jump_link,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [4:0]        id_shamt,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_dest,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_jump_reg,
    output logic              ex_jump_link,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic              ex_valid,
    output logic              load_use_hazard
);

    localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [2:0]        alu_op;
        logic              alu_src;
        logic              reg_dest;
        logic              branch;
        logic              jump;
        logic              jump_reg;
        logic              jump_link;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc_plus4;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [4:0]        shamt;
        logic [REG_W-1:0]  write_reg;
        logic              valid;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;

    // A load in EX whose destination matches either decode source field.
    // rt is compared even for instructions that do not read it: a spare
    // bubble is cheaper than decoding which fields are really sources.
    // Register 0 is hardwired, so it can never carry a dependency.
    assign load_use_hazard = ex_q.valid & ex_q.mem_to_reg
                           & (ex_q.write_reg != '0)
                           & ((ex_q.write_reg == id_rs) | (ex_q.write_reg == id_rt));

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_hazard) begin
            // The bubble is all-zero, so no write/branch/jump leaks downstream.
            // ex_valid drops, which clears the hazard and lets the held decode
            // instruction be captured on the following edge.
            ex_d = '0;
        end else begin
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            ex_d.mem_write  = id_mem_write;
            ex_d.alu_op     = id_alu_op;
            ex_d.alu_src    = id_alu_src;
            ex_d.reg_dest   = id_reg_dest;
            ex_d.branch     = id_branch;
            ex_d.jump       = id_jump;
            ex_d.jump_reg   = id_jump_reg;
            ex_d.jump_link  = id_jump_link;
            ex_d.rd1        = id_rd1;
            ex_d.rd2        = id_rd2;
            ex_d.imm        = id_imm;
            ex_d.pc_plus4   = id_pc_plus4;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            ex_d.shamt      = id_shamt;
            ex_d.write_reg  = id_jump_link ? LINK_IDX : (id_reg_dest ? id_rd : id_rt);
            ex_d.valid      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_dest   = ex_q.reg_dest;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_jump_reg   = ex_q.jump_reg;
    assign ex_jump_link  = ex_q.jump_link;
    assign ex_rd1        = ex_q.rd1;
    assign ex_rd2        = ex_q.rd2;
    assign ex_imm        = ex_q.imm;
    assign ex_pc_plus4   = ex_q.pc_plus4;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_shamt      = ex_q.shamt;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_valid      = ex_q.valid;

endmodule
